// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller.
// Stall-bus width, stage indices, stage-to-mask helper, FSM state type.
package pipe_hazard_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef enum logic {
        TS_IDLE = 1'b0,
        TS_BUSY = 1'b1
    } tstate_e;

    // Freezing stage k freezes every stage upstream of it as well.
    function automatic logic [31:0] stage_mask(input int k);
        logic [32:0] w_m;
        w_m = (33'd1 << (k + 1)) - 33'd1;
        return w_m[31:0];
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_tstall.sv
// Timed multi-cycle stall: IDLE/BUSY FSM with a down-counter.
// o_active covers the start cycle combinationally and every BUSY cycle.
module tstall_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_active
);

    tstate_e          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_go;

    assign w_go     = (r_state == TS_IDLE) && i_start && (i_len != '0);
    assign o_busy   = (r_state == TS_BUSY);
    assign o_active = o_busy || w_go;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= TS_IDLE;
            r_cnt   <= '0;
        end else if (i_flush) begin
            r_state <= TS_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                TS_IDLE: begin
                    if (w_go) begin
                        r_cnt <= i_len - CNT_W'(1);
                        if (i_len > CNT_W'(1)) r_state <= TS_BUSY;
                    end
                end
                TS_BUSY: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= TS_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= TS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush controller: merges stall requests, timed stalls,
// registered flush with redirect PC, stall watchdog and perf counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int               STAGES       = STALL_BUS_W,
    parameter int               NREQ         = 2,
    parameter logic [NREQ*8-1:0] REQ_STAGE   = {8'd3, 8'd2},
    parameter int               TSTALL_STAGE = 3,
    parameter int               CNT_W        = 6,
    parameter int               WDOG_LIMIT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stall_req,
    input  logic              tstall_start,
    input  logic [CNT_W-1:0]  tstall_len,
    output logic              tstall_busy,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic [STAGES-1:0] stall,
    output logic              stall_timeout,
    output logic [31:0]       stall_cycles
);

    logic        r_flush;
    logic [31:0] r_pc;
    logic [31:0] r_cycles;
    logic        w_ts_active;
    logic [31:0] w_mask;
    logic        w_stall_any;

    tstall_counter #(
        .CNT_W(CNT_W)
    ) u_tstall (
        .clk     (clk),
        .rst     (rst),
        .i_start (tstall_start),
        .i_len   (tstall_len),
        .i_flush (r_flush),
        .o_busy  (tstall_busy),
        .o_active(w_ts_active)
    );

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stall_req[i]) w_mask = w_mask | stage_mask(int'(REQ_STAGE[i*8 +: 8]));
        end
        if (w_ts_active) w_mask = w_mask | stage_mask(TSTALL_STAGE);
    end

    // Flush beats any stall; reset forces the bus quiet.
    assign stall       = (rst && !r_flush) ? w_mask[STAGES-1:0] : '0;
    assign w_stall_any = (stall != '0);

    assign flush        = r_flush;
    assign new_pc       = r_pc;
    assign stall_cycles = r_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush <= 1'b0;
            r_pc    <= '0;
        end else begin
            r_flush <= flush_req;
            if (flush_req) r_pc <= flush_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycles <= '0;
        end else if (stall[0] && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    generate
        if (WDOG_LIMIT == 0) begin : g_no_wdog
            assign stall_timeout = 1'b0;
        end else begin : g_wdog
            localparam int WD_W = $clog2(WDOG_LIMIT + 1);
            localparam logic [WD_W-1:0] LIM = WD_W'(WDOG_LIMIT);
            logic [WD_W-1:0] r_wd;
            logic            r_to;

            assign stall_timeout = r_to;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_wd <= '0;
                    r_to <= 1'b0;
                end else if (w_stall_any) begin
                    if (r_wd != LIM) r_wd <= r_wd + WD_W'(1);
                    if (r_wd >= LIM - WD_W'(1)) r_to <= 1'b1;
                end else begin
                    r_wd <= '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl.
// Watchdog limit shrunk to 16 so the timeout is reachable quickly.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  stall_req;
    logic        tstall_start;
    logic [5:0]  tstall_len;
    logic        tstall_busy;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        flush;
    logic [31:0] new_pc;
    logic [5:0]  stall;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(
        .WDOG_LIMIT(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req    (stall_req),
        .tstall_start (tstall_start),
        .tstall_len   (tstall_len),
        .tstall_busy  (tstall_busy),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall        (stall),
        .stall_timeout(stall_timeout),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout sim time limit reached");
        $fatal(1, "simulation time limit");
    end

    typedef struct {
        logic [1:0]  req;
        logic        ts;
        logic [5:0]  len;
        logic        fr;
        logic [31:0] fpc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic        e_busy;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic [1:0] req, input logic ts,
                                input logic [5:0] len, input logic fr,
                                input logic [31:0] fpc, input logic [5:0] es,
                                input logic ef, input logic eb,
                                input logic [31:0] ep);
        vec_t v;
        v.req = req; v.ts = ts; v.len = len; v.fr = fr; v.fpc = fpc;
        v.e_stall = es; v.e_flush = ef; v.e_busy = eb; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h want %h", name, row, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic ts,
                         input logic [5:0] len, input logic fr,
                         input logic [31:0] fpc);
        stall_req = req; tstall_start = ts; tstall_len = len;
        flush_req = fr; flush_pc = fpc;
    endtask

    int cyc_model;

    initial begin
        // req ts len fr fpc | stall flush busy new_pc
        tbl[0]  = mk(2'b01, 0, 0, 0, 0, 6'b000111, 0, 0, 0);
        tbl[1]  = mk(2'b10, 0, 0, 0, 0, 6'b001111, 0, 0, 0);
        tbl[2]  = mk(2'b11, 0, 0, 0, 0, 6'b001111, 0, 0, 0);
        tbl[3]  = mk(2'b00, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        tbl[4]  = mk(2'b00, 1, 4, 0, 0, 6'b001111, 0, 0, 0);
        tbl[5]  = mk(2'b00, 0, 0, 0, 0, 6'b001111, 0, 1, 0);
        tbl[6]  = mk(2'b00, 1, 2, 0, 0, 6'b001111, 0, 1, 0);
        tbl[7]  = mk(2'b00, 0, 0, 0, 0, 6'b001111, 0, 1, 0);
        tbl[8]  = mk(2'b00, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        tbl[9]  = mk(2'b00, 1, 1, 0, 0, 6'b001111, 0, 0, 0);
        tbl[10] = mk(2'b00, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        tbl[11] = mk(2'b00, 1, 0, 0, 0, 6'b000000, 0, 0, 0);
        tbl[12] = mk(2'b10, 0, 0, 1, 32'hBFC00380, 6'b001111, 0, 0, 0);
        tbl[13] = mk(2'b10, 0, 0, 0, 0, 6'b000000, 1, 0, 32'hBFC00380);
        tbl[14] = mk(2'b10, 0, 0, 0, 0, 6'b001111, 0, 0, 32'hBFC00380);
        tbl[15] = mk(2'b00, 1, 8, 0, 0, 6'b001111, 0, 0, 32'hBFC00380);
        tbl[16] = mk(2'b00, 0, 0, 0, 0, 6'b001111, 0, 1, 32'hBFC00380);
        tbl[17] = mk(2'b00, 0, 0, 0, 0, 6'b001111, 0, 1, 32'hBFC00380);
        tbl[18] = mk(2'b00, 0, 0, 1, 32'h80000180, 6'b001111, 0, 1, 32'hBFC00380);
        tbl[19] = mk(2'b00, 1, 5, 0, 0, 6'b000000, 1, 1, 32'h80000180);
        tbl[20] = mk(2'b00, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h80000180);
        tbl[21] = mk(2'b00, 0, 0, 1, 32'h100, 6'b000000, 0, 0, 32'h80000180);
        tbl[22] = mk(2'b00, 0, 0, 1, 32'h200, 6'b000000, 1, 0, 32'h100);
        tbl[23] = mk(2'b00, 0, 0, 0, 0, 6'b000000, 1, 0, 32'h200);
        tbl[24] = mk(2'b00, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h200);

        rst = 1'b0;
        drive(2'b11, 1'b1, 6'd4, 1'b1, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", -1, 32'(stall), 0);
        chk("rst_flush", -1, 32'(flush), 0);
        chk("rst_pc", -1, new_pc, 0);
        chk("rst_busy", -1, 32'(tstall_busy), 0);
        chk("rst_cycles", -1, stall_cycles, 0);
        chk("rst_timeout", -1, 32'(stall_timeout), 0);

        @(negedge clk);
        rst = 1'b1;
        cyc_model = 0;
        for (int i = 0; i < 25; i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].req, tbl[i].ts, tbl[i].len, tbl[i].fr, tbl[i].fpc);
            #1;
            chk("stall", i, 32'(stall), 32'(tbl[i].e_stall));
            chk("flush", i, 32'(flush), 32'(tbl[i].e_flush));
            chk("busy", i, 32'(tstall_busy), 32'(tbl[i].e_busy));
            chk("new_pc", i, new_pc, tbl[i].e_pc);
            chk("cycles", i, stall_cycles, 32'(cyc_model));
            chk("timeout", i, 32'(stall_timeout), 0);
            if (tbl[i].e_stall[0]) cyc_model++;
        end

        // Asynchronous reset mid timed stall.
        @(negedge clk);
        drive(2'b00, 1'b1, 6'd8, 1'b0, 0);
        @(negedge clk);
        drive(2'b00, 1'b0, 6'd0, 1'b1, 32'h1234);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", 0, 32'(tstall_busy), 1);
        chk("pre_rst_flush", 0, 32'(flush), 1);
        rst = 1'b0;
        #1;
        chk("arst_stall", 0, 32'(stall), 0);
        chk("arst_flush", 0, 32'(flush), 0);
        chk("arst_busy", 0, 32'(tstall_busy), 0);
        chk("arst_cycles", 0, stall_cycles, 0);
        @(negedge clk);
        drive(2'b00, 1'b0, 6'd0, 1'b0, 0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_rst_stall", k, 32'(stall), 0);
            chk("post_rst_busy", k, 32'(tstall_busy), 0);
            @(negedge clk);
        end

        // Watchdog: fresh reset, then hold a load-use stall.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(2'b01, 1'b0, 6'd0, 1'b0, 0);
        for (int k = 0; k < 20; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("wd_timeout", k, 32'(stall_timeout), (k >= 16) ? 1 : 0);
            chk("wd_cycles", k, stall_cycles, 32'(k));
        end
        @(negedge clk);
        drive(2'b00, 1'b0, 6'd0, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wd_sticky", k, 32'(stall_timeout), 1);
            chk("wd_hold_cycles", k, stall_cycles, 32'd20);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
